// File: rtl/bit_stream_serializer.sv
// -----------------------------------------------------------------------------
// bit_stream_serializer
//
// Parallel-to-serial stage feeding the serial sequence detectors. Words arrive
// over a valid/ready handshake into a holding register, move to a shift
// register, and leave MSB first, one bit per cycle where bit_en=1. A word
// waiting in the holding register is reloaded on the same edge that consumes
// the last bit of the current word, so consecutive words stream with no idle
// gap and patterns straddling a word boundary survive.
//
// Optional feature: define SERIALIZER_PARITY_EN to append an even-parity bit
// (XOR of the word) after each word's data bits.
//
// Ports:
//   clk        in   1      clock, rising edge
//   reset      in   1      synchronous, active-high
//   in_data    in   WIDTH  parallel word to serialize
//   in_valid   in   1      in_data valid
//   in_ready   out  1      word can be accepted this cycle
//   bit_en     in   1      shift strobe; current bit consumed when high
//   out_bit    out  1      serial data, MSB first; 0 when out_valid=0
//   out_valid  out  1      out_bit carries a data (or parity) bit
//   busy       out  1      holding register full or shifter active
//   words_sent out  CNT_W  count of fully transmitted words (wraps)
// -----------------------------------------------------------------------------
module bit_stream_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             bit_en,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

    localparam int BC_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
`ifdef SERIALIZER_PARITY_EN
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
`else
        S_SHIFT  = 2'd1
`endif
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [WIDTH-1:0] r_sh;
    logic [BC_W-1:0]  r_bit_cnt;
    logic [CNT_W-1:0] r_words;
`ifdef SERIALIZER_PARITY_EN
    logic             r_par;
`endif

    logic w_accept;
    logic w_load;
    logic w_shift;
    logic w_done;
    logic w_out_valid;
    logic w_out_bit;

    // in_ready depends only on the flop: a word cannot slip in on the same
    // edge that the holding register drains into the shifter.
    assign w_accept = in_valid && !r_hold_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        w_out_valid = 1'b0;
        w_out_bit   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Transfer into the shifter does not wait for bit_en.
                if (r_hold_full) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_out_valid = 1'b1;
                w_out_bit   = r_sh[WIDTH-1];
                if (bit_en) begin
                    if (r_bit_cnt != '0) begin
                        w_shift = 1'b1;
                    end else begin
`ifdef SERIALIZER_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_done = 1'b1;
                        if (r_hold_full) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
`endif
                    end
                end
            end
`ifdef SERIALIZER_PARITY_EN
            S_PARITY: begin
                w_out_valid = 1'b1;
                w_out_bit   = r_par;
                if (bit_en) begin
                    w_done = 1'b1;
                    if (r_hold_full) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_SHIFT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control state: cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_full <= 1'b0;
            r_bit_cnt   <= '0;
            r_words     <= '0;
        end else begin
            // A load only happens while the holding register is full, so it
            // never coincides with an accept.
            if (w_load) begin
                r_hold_full <= 1'b0;
            end else if (w_accept) begin
                r_hold_full <= 1'b1;
            end
            if (w_load) begin
                r_bit_cnt <= BC_W'(WIDTH - 1);
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt - 1'b1;
            end
            if (w_done) begin
                r_words <= r_words + 1'b1;
            end
        end
    end

    // Data registers: contents are only observed while the control state
    // marks them valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hold <= in_data;
        end
        if (w_load) begin
            r_sh <= r_hold;
        end else if (w_shift) begin
            r_sh <= {r_sh[WIDTH-2:0], 1'b0};
        end
`ifdef SERIALIZER_PARITY_EN
        if (w_load) begin
            r_par <= ^r_hold;
        end
`endif
    end

    assign in_ready   = !r_hold_full;
    assign out_valid  = w_out_valid;
    assign out_bit    = w_out_bit;
    assign busy       = r_hold_full || (r_state != S_IDLE);
    assign words_sent = r_words;

endmodule

// File: tb/tb_bit_stream_serializer.sv
module tb_bit_stream_serializer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 6;
`ifdef SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             bit_en = 1'b1;
    logic             out_bit;
    logic             out_valid;
    logic             busy;
    logic [CNT_W-1:0] words_sent;

    always #5 clk = ~clk;

    bit_stream_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .bit_en(bit_en), .out_bit(out_bit),
        .out_valid(out_valid), .busy(busy), .words_sent(words_sent)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The line is a queue of bits still to be presented for the current word;
    // the holding register is a single optional slot.
    logic             m_bits[$];
    logic [WIDTH-1:0] m_hold;
    bit               m_hold_full = 1'b0;
    bit               m_active = 1'b0;
    logic [CNT_W-1:0] m_words = '0;
    bit               chk_en = 1'b0;

    task automatic m_load();
        for (int i = WIDTH - 1; i >= 0; i--) m_bits.push_back(m_hold[i]);
`ifdef SERIALIZER_PARITY_EN
        m_bits.push_back(^m_hold);
`endif
        m_hold_full = 1'b0;
    endtask

    initial forever begin
        bit acc;
        @(posedge clk);
        if (reset) begin
            m_hold_full = 1'b0;
            m_active    = 1'b0;
            m_bits.delete();
            m_words     = '0;
        end else begin
            acc = in_valid && !m_hold_full;
            if (m_active) begin
                if (bit_en) begin
                    void'(m_bits.pop_front());
                    if (m_bits.size() == 0) begin
                        m_words = m_words + 1'b1;
                        if (m_hold_full) m_load();
                        else m_active = 1'b0;
                    end
                end
            end else if (m_hold_full) begin
                m_load();
                m_active = 1'b1;
            end
            if (acc) begin
                m_hold      = in_data;
                m_hold_full = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("model in_ready", in_ready, !m_hold_full);
            check("model out_valid", out_valid, m_active);
            check("model out_bit", out_bit, m_active ? m_bits[0] : 1'b0);
            check("model busy", busy, m_hold_full || m_active);
            check("model words_sent", words_sent, m_words);
        end
    end

    // ---------------- directed stimulus helpers ----------------
    logic rec_v[64];
    logic rec_b[64];
    logic rec_rdy[64];

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; bit_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Offers up to two words with a held in_valid, recording the line each cycle.
    task automatic run(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                       input int nw, input bit toggle, input int ncyc);
        int   idx;
        logic prev_rdy;
        idx = 0;
        prev_rdy = in_ready;
        in_data  = w0;
        in_valid = (nw > 0);
        bit_en   = !toggle;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            rec_v[c] = out_valid; rec_b[c] = out_bit; rec_rdy[c] = in_ready;
            if (in_valid && prev_rdy) idx++;
            prev_rdy = in_ready;
            in_valid = (idx < nw);
            in_data  = (idx == 0) ? w0 : w1;
            if (toggle) bit_en = !bit_en;
        end
        in_valid = 1'b0;
        bit_en   = 1'b1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        bit done;
        done = 1'b0;
        in_valid = 1'b1; in_data = d;
        for (int t = 0; t < 100 && !done; t++) begin
            done = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("push accepted", done, 1'b1);
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && busy; t++) @(negedge clk);
        check("drain idle", busy, 1'b0);
    endtask

    initial begin
        logic [7:0]  b8;
        logic [15:0] b16;
        logic [2:0]  b3;
        int          cnt, ones;

        @(negedge clk);
        do_reset();
        chk_en = 1'b1;
        check("reset in_ready", in_ready, 1'b1);
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_bit", out_bit, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset words_sent", words_sent, 0);

        // 0xB0 single word
        run(8'hB0, 8'h00, 1, 1'b0, 12);
        check("t1 in_ready after accept", rec_rdy[0], 1'b0);
        check("t1 no bit before transfer", rec_v[0], 1'b0);
        for (int i = 0; i < 8; i++) b8[7-i] = rec_b[1+i];
        check("t1 bits", b8, 8'hB0);
        cnt = 0;
        for (int c = 0; c < 12; c++) cnt += int'(rec_v[c]);
        check("t1 valid cycles", cnt, 8 + PAR);
`ifdef SERIALIZER_PARITY_EN
        check("t1 parity", rec_b[9], 1'b1);
`endif
        check("t1 idle valid", rec_v[9+PAR], 1'b0);
        check("t1 idle bit", rec_b[9+PAR], 1'b0);
        check("t1 words_sent", words_sent, 1);
        check("t1 model words", m_words, 1);

        // 0x05 then 0x80 back to back
        do_reset();
        run(8'h05, 8'h80, 2, 1'b0, 24);
        check("t2 second word stalled", rec_rdy[0], 1'b0);
        for (int k = 0; k < 16; k++) b16[15-k] = rec_b[1 + k + ((k >= 8) ? PAR : 0)];
        check("t2 bits", b16, 16'h0580);
        cnt = 0;
        for (int c = 1; c <= 16 + 2*PAR; c++) cnt += int'(rec_v[c]);
        check("t2 no gap", cnt, 16 + 2*PAR);
        check("t2 idle after", rec_v[17+2*PAR], 1'b0);
`ifdef SERIALIZER_PARITY_EN
        check("t2 parity 05", rec_b[9], 1'b0);
        check("t2 parity 80", rec_b[18], 1'b1);
`endif
        check("t2 words_sent", words_sent, 2);

        // 0xFF with bit_en toggling
        do_reset();
        run(8'hFF, 8'h00, 1, 1'b1, 22);
        cnt = 0; ones = 0;
        for (int c = 0; c < 22; c++) begin
            cnt  += int'(rec_v[c]);
            ones += int'(rec_b[c]);
        end
        check("t3 valid cycles", cnt, 16 + 2*PAR);
        check("t3 one cycles", ones, 16);
        check("t3 held pair", {rec_b[1], rec_b[2], rec_v[1], rec_v[2]}, 4'b1111);

        // reset mid-word with a word held
        do_reset();
        run(8'hA5, 8'h3C, 2, 1'b0, 4);
        b3 = {rec_b[1], rec_b[2], rec_b[3]};
        check("t4 first bits", b3, 3'b101);
        check("t4 held", rec_rdy[3], 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t4 out_valid", out_valid, 1'b0);
        check("t4 out_bit", out_bit, 1'b0);
        check("t4 in_ready", in_ready, 1'b1);
        check("t4 busy", busy, 1'b0);
        check("t4 words_sent", words_sent, 0);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            cnt += int'(out_valid);
        end
        check("t4 discarded word", cnt, 0);

`ifdef SERIALIZER_PARITY_EN
        do_reset();
        run(8'h07, 8'h00, 1, 1'b0, 12);
        for (int i = 0; i < 8; i++) b8[7-i] = rec_b[1+i];
        check("t5 bits 07", b8, 8'h07);
        check("t5 parity 07", rec_b[9], 1'b1);
        run(8'h03, 8'h00, 1, 1'b0, 12);
        for (int i = 0; i < 8; i++) b8[7-i] = rec_b[1+i];
        check("t5 bits 03", b8, 8'h03);
        check("t5 parity 03", rec_b[9], 1'b0);
`endif

        // words_sent wrap
        do_reset();
        for (int w = 0; w < (1 << CNT_W) - 1; w++) push(8'(w));
        drain();
        check("wrap max", words_sent, (1 << CNT_W) - 1);
        push(8'h5A);
        drain();
        check("wrap zero", words_sent, 0);
        check("wrap model", m_words, 0);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset    = ($urandom_range(0, 599) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = WIDTH'($urandom);
            bit_en   = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; bit_en = 1'b1;
        repeat (30) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
